// File: rtl/bus_dma_pkg.sv
// Shared definitions for the bus_dma memory-to-memory DMA engine.
// Optional fill mode is enabled by defining BUS_DMA_FILL_EN.
package bus_dma_pkg;

  localparam logic [2:0] REG_SRC     = 3'd0;
  localparam logic [2:0] REG_DST     = 3'd1;
  localparam logic [2:0] REG_LEN     = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
  localparam logic [2:0] REG_PATTERN = 3'd4;

  localparam int CTRL_START  = 0;
  localparam int CTRL_DONE   = 1;
  localparam int CTRL_ERR    = 2;
  localparam int CTRL_IRQ_EN = 3;
  localparam int CTRL_FILL   = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    FINISH  = 3'd5
  } dma_state_e;

endpackage

// File: rtl/bus_dma_regs.sv
// Register file of bus_dma: decode, readback and DONE/ERR/IRQ_EN storage.
// FILL and PATTERN exist only when BUS_DMA_FILL_EN is defined.
module bus_dma_regs
  import bus_dma_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 device_req_i,
  input  logic [AddrWidth-1:0] device_addr_i,
  input  logic                 device_we_i,
  input  logic [3:0]           device_be_i,
  input  logic [31:0]          device_wdata_i,
  output logic                 device_rvalid_o,
  output logic [31:0]          device_rdata_o,
  input  logic                 busy,
  input  logic                 set_done,
  input  logic                 set_err,
  output logic [AddrWidth-1:0] src,
  output logic [AddrWidth-1:0] dst,
  output logic [LenWidth-1:0]  len,
  output logic                 start,
  output logic                 fill,
  output logic [31:0]          pattern,
  output logic                 irq
);

  logic [2:0]  reg_sel;
  logic        wr_en;
  logic        wr_ctrl;
  logic        done;
  logic        err;
  logic        irq_en;
  logic [31:0] rdata_d;
  logic [31:0] ctrl_read;
  logic        unused_addr;

  assign reg_sel     = device_addr_i[4:2];
  assign wr_en       = device_req_i && device_we_i && (device_be_i == 4'hF);
  assign wr_ctrl     = wr_en && (reg_sel == REG_CTRL);
  assign start       = wr_ctrl && device_wdata_i[CTRL_START] && !busy;
  assign irq         = done && irq_en;
  assign unused_addr = ^{device_addr_i[AddrWidth-1:5], device_addr_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src <= '0;
      dst <= '0;
      len <= '0;
    end else if (wr_en && !busy) begin
      case (reg_sel)
        REG_SRC: src <= AddrWidth'(device_wdata_i & 32'hFFFF_FFFC);
        REG_DST: dst <= AddrWidth'(device_wdata_i & 32'hFFFF_FFFC);
        REG_LEN: len <= device_wdata_i[LenWidth-1:0];
        default: ;
      endcase
    end
  end

  // Completion flags: hardware set beats START, START beats write-1-to-clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done   <= 1'b0;
      err    <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      if (set_done) begin
        done <= 1'b1;
      end else if (start || (wr_ctrl && device_wdata_i[CTRL_DONE])) begin
        done <= 1'b0;
      end
      if (set_err) begin
        err <= 1'b1;
      end else if (start || (wr_ctrl && device_wdata_i[CTRL_ERR])) begin
        err <= 1'b0;
      end
      if (wr_ctrl) begin
        irq_en <= device_wdata_i[CTRL_IRQ_EN];
      end
    end
  end

`ifdef BUS_DMA_FILL_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill    <= 1'b0;
      pattern <= '0;
    end else begin
      if (wr_ctrl && !busy) begin
        fill <= device_wdata_i[CTRL_FILL];
      end
      if (wr_en && (reg_sel == REG_PATTERN)) begin
        pattern <= device_wdata_i;
      end
    end
  end
`else
  assign fill    = 1'b0;
  assign pattern = '0;
`endif

  assign ctrl_read = {27'd0, fill, irq_en, err, done, busy};

  always_comb begin
    rdata_d = '0;
    case (reg_sel)
      REG_SRC:     rdata_d = 32'(src);
      REG_DST:     rdata_d = 32'(dst);
      REG_LEN:     rdata_d = 32'(len);
      REG_CTRL:    rdata_d = ctrl_read;
      REG_PATTERN: rdata_d = pattern;
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
    end else begin
      device_rvalid_o <= device_req_i;
      device_rdata_o  <= (device_req_i && !device_we_i) ? rdata_d : '0;
    end
  end

endmodule

// File: rtl/bus_dma.sv
// Word-granular memory-to-memory DMA engine: bus host FSM plus pointer/count datapath.
// Define BUS_DMA_FILL_EN to add the pattern-fill mode (write-only transfers).
module bus_dma
  import bus_dma_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 device_req_i,
  input  logic [AddrWidth-1:0] device_addr_i,
  input  logic                 device_we_i,
  input  logic [3:0]           device_be_i,
  input  logic [31:0]          device_wdata_i,
  output logic                 device_rvalid_o,
  output logic [31:0]          device_rdata_o,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic [AddrWidth-1:0] host_addr_o,
  output logic                 host_we_o,
  output logic [3:0]           host_be_o,
  output logic [DataWidth-1:0] host_wdata_o,
  input  logic                 host_rvalid_i,
  input  logic [DataWidth-1:0] host_rdata_i,
  input  logic                 host_err_i,
  output logic                 irq_o
);

  dma_state_e           state_q, state_d;
  logic [AddrWidth-1:0] src, dst, src_ptr, dst_ptr;
  logic [LenWidth-1:0]  len, remaining;
  logic [DataWidth-1:0] data_q;
  logic [31:0]          pattern;
  logic                 start, fill, busy, set_done, set_err;

  assign busy = (state_q != IDLE);

  bus_dma_regs #(
    .AddrWidth(AddrWidth),
    .LenWidth (LenWidth)
  ) u_regs (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .device_req_i   (device_req_i),
    .device_addr_i  (device_addr_i),
    .device_we_i    (device_we_i),
    .device_be_i    (device_be_i),
    .device_wdata_i (device_wdata_i),
    .device_rvalid_o(device_rvalid_o),
    .device_rdata_o (device_rdata_o),
    .busy           (busy),
    .set_done       (set_done),
    .set_err        (set_err),
    .src            (src),
    .dst            (dst),
    .len            (len),
    .start          (start),
    .fill           (fill),
    .pattern        (pattern),
    .irq            (irq_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) state_d = FINISH;
          else           state_d = fill ? WR_REQ : RD_REQ;
        end
      end
      RD_REQ:  if (host_gnt_i) state_d = RD_WAIT;
      RD_WAIT: if (host_rvalid_i) state_d = host_err_i ? FINISH : WR_REQ;
      WR_REQ:  if (host_gnt_i) state_d = WR_WAIT;
      WR_WAIT: begin
        // remaining is still the pre-decrement count here
        if (host_rvalid_i) begin
          if (host_err_i || (remaining == LenWidth'(1))) state_d = FINISH;
          else                                            state_d = fill ? WR_REQ : RD_REQ;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    host_req_o   = 1'b0;
    host_we_o    = 1'b0;
    host_be_o    = 4'h0;
    host_addr_o  = '0;
    host_wdata_o = '0;
    set_done     = 1'b0;
    set_err      = 1'b0;
    case (state_q)
      RD_REQ: begin
        host_req_o  = 1'b1;
        host_be_o   = 4'hF;
        host_addr_o = src_ptr;
      end
      WR_REQ: begin
        host_req_o   = 1'b1;
        host_we_o    = 1'b1;
        host_be_o    = 4'hF;
        host_addr_o  = dst_ptr;
        host_wdata_o = fill ? DataWidth'(pattern) : data_q;
      end
      RD_WAIT, WR_WAIT: set_err = host_rvalid_i && host_err_i;
      FINISH:           set_done = 1'b1;
      default: ;
    endcase
  end

  // Working copies so the programmed SRC/DST/LEN stay readable during a transfer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      data_q    <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        src_ptr   <= src;
        dst_ptr   <= dst;
        remaining <= len;
      end
      if (state_q == RD_WAIT && host_rvalid_i) begin
        data_q <= host_rdata_i;
      end
      if (state_q == WR_WAIT && host_rvalid_i) begin
        src_ptr   <= src_ptr + AddrWidth'(4);
        dst_ptr   <= dst_ptr + AddrWidth'(4);
        remaining <= remaining - LenWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_dma.sv
// Self-checking bench for bus_dma: randomized bus responder plus a transaction-level reference model.
module tb_bus_dma;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        device_req_i = 1'b0;
  logic [31:0] device_addr_i = '0;
  logic        device_we_i = 1'b0;
  logic [3:0]  device_be_i = '0;
  logic [31:0] device_wdata_i = '0;
  logic        device_rvalid_o;
  logic [31:0] device_rdata_o;
  logic        host_req_o;
  logic        host_gnt_i = 1'b0;
  logic [31:0] host_addr_o;
  logic        host_we_o;
  logic [3:0]  host_be_o;
  logic [31:0] host_wdata_o;
  logic        host_rvalid_i = 1'b0;
  logic [31:0] host_rdata_i = '0;
  logic        host_err_i = 1'b0;
  logic        irq_o;

  bus_dma dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .device_req_i   (device_req_i),
    .device_addr_i  (device_addr_i),
    .device_we_i    (device_we_i),
    .device_be_i    (device_be_i),
    .device_wdata_i (device_wdata_i),
    .device_rvalid_o(device_rvalid_o),
    .device_rdata_o (device_rdata_o),
    .host_req_o     (host_req_o),
    .host_gnt_i     (host_gnt_i),
    .host_addr_o    (host_addr_o),
    .host_we_o      (host_we_o),
    .host_be_o      (host_be_o),
    .host_wdata_o   (host_wdata_o),
    .host_rvalid_i  (host_rvalid_i),
    .host_rdata_i   (host_rdata_i),
    .host_err_i     (host_err_i),
    .irq_o          (irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        log_q[$];
  txn_t        exp_q[$];
  logic [31:0] mem[int unsigned];
  logic [31:0] src_words[16];

  int total = 0;
  int bad = 0;
  int rd_cnt = 0, wr_cnt = 0;
  int stall_left = 0, stall_max = 0;
  int stall_rd_idx = -1, stall_rd_len = 0, stall_wr_fixed = 0, err_wr_idx = -1;
  int stable_checks = 0;
  bit in_prog = 0, pend = 0, pend_err = 0;
  txn_t pend_t;
  logic prev_req = 0, prev_gnt = 0, prev_we = 0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  task automatic check_output(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus slave: grants after a chosen stall, answers one cycle after the grant
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      host_gnt_i    = 1'b0;
      host_rvalid_i = 1'b0;
      host_err_i    = 1'b0;
      host_rdata_i  = '0;
      pend          = 0;
      in_prog       = 0;
      prev_req      = 0;
      prev_gnt      = 0;
    end else begin
      if (prev_req && !prev_gnt) begin
        stable_checks++;
        check_output("req_held", 96'(host_req_o), 96'(1));
        check_output("addr_stable", 96'(host_addr_o), 96'(prev_addr));
        check_output("we_stable", 96'(host_we_o), 96'(prev_we));
        check_output("wdata_stable", 96'(host_wdata_o), 96'(prev_wdata));
      end
      host_rvalid_i = 1'b0;
      host_err_i    = 1'b0;
      host_rdata_i  = '0;
      if (pend) begin
        host_rvalid_i = 1'b1;
        host_err_i    = pend_err;
        host_rdata_i  = pend_t.we ? 32'd0 : pend_t.data;
        pend = 0;
      end
      host_gnt_i = 1'b0;
      if (host_req_o) begin
        if (!in_prog) begin
          in_prog = 1;
          if (!host_we_o)
            stall_left = (rd_cnt == stall_rd_idx) ? stall_rd_len : int'($urandom_range(0, stall_max));
          else
            stall_left = (stall_wr_fixed > 0) ? stall_wr_fixed : int'($urandom_range(0, stall_max));
        end
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          txn_t t;
          host_gnt_i = 1'b1;
          in_prog = 0;
          t.we   = host_we_o;
          t.addr = host_addr_o;
          if (host_we_o) begin
            t.data   = host_wdata_o;
            pend_err = (wr_cnt == err_wr_idx);
            if (!pend_err) mem[host_addr_o] = host_wdata_o;
            wr_cnt++;
          end else begin
            t.data   = mem.exists(host_addr_o) ? mem[host_addr_o] : 32'd0;
            pend_err = 0;
            rd_cnt++;
          end
          log_q.push_back(t);
          pend_t = t;
          pend   = 1;
        end
      end
      prev_req   = host_req_o;
      prev_gnt   = host_gnt_i;
      prev_we    = host_we_o;
      prev_addr  = host_addr_o;
      prev_wdata = host_wdata_o;
    end
  end

  task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk_i);
    device_req_i   = 1'b1;
    device_we_i    = 1'b1;
    device_be_i    = 4'hF;
    device_addr_i  = a;
    device_wdata_i = d;
    @(negedge clk_i);
    device_req_i = 1'b0;
    device_we_i  = 1'b0;
    device_be_i  = 4'h0;
  endtask

  task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk_i);
    device_req_i  = 1'b1;
    device_we_i   = 1'b0;
    device_addr_i = a;
    @(negedge clk_i);
    check_output("rvalid", 96'(device_rvalid_o), 96'(1));
    d = device_rdata_o;
    device_req_i = 1'b0;
  endtask

  task automatic prepare(input logic [31:0] src, input logic [31:0] dst, input int n);
    log_q.delete();
    rd_cnt = 0;
    wr_cnt = 0;
    stable_checks = 0;
    for (int i = 0; i < n; i++) begin
      src_words[i] = $urandom;
      mem[src + 32'(4 * i)] = src_words[i];
      mem[dst + 32'(4 * i)] = 32'hDEAD_0000 + 32'(i);
    end
  endtask

  // Reference: word i is read from SRC+4i then written to DST+4i, stopping after an erroring write
  task automatic build_expected(input logic [31:0] src, input logic [31:0] dst, input int n, input int err_at);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{we: 1'b0, addr: src + 32'(4 * i), data: src_words[i]});
      exp_q.push_back('{we: 1'b1, addr: dst + 32'(4 * i), data: src_words[i]});
      if (i == err_at) break;
    end
  endtask

  task automatic compare_log(input string tag);
    check_output({tag, "_count"}, 96'(log_q.size()), 96'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_q.size())
        check_output($sformatf("%s_txn%0d", tag, i), 96'(log_q[i]), 96'(exp_q[i]));
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic [31:0] c;
    int n = 0;
    do begin
      reg_read(32'hC, c);
      n++;
    end while (c[1] == 1'b0 && n < budget);
    check_output({tag, "_done_seen"}, 96'(c[1]), 96'(1));
  endtask

  initial begin
    logic [31:0] rd;
    bit found;

    $display("[TB] reset checks");
    repeat (3) @(negedge clk_i);
    check_output("rst_req", 96'(host_req_o), 96'(0));
    check_output("rst_we", 96'(host_we_o), 96'(0));
    check_output("rst_irq", 96'(irq_o), 96'(0));
    check_output("rst_rvalid", 96'(device_rvalid_o), 96'(0));
    rst_ni = 1'b1;
    reg_read(32'hC, rd);
    check_output("rst_ctrl", 96'(rd), 96'(0));
    reg_read(32'h0, rd);
    check_output("rst_src", 96'(rd), 96'(0));
    reg_read(32'h8, rd);
    check_output("rst_len", 96'(rd), 96'(0));

    $display("[TB] test 1: four-word copy");
    stall_max = 2;
    prepare(32'h0010_0000, 32'h0010_0100, 4);
    reg_write(32'h0, 32'h0010_0003);
    reg_write(32'h4, 32'h0010_0100);
    reg_write(32'h8, 32'd4);
    reg_read(32'h0, rd);
    check_output("t1_src_lowbits", 96'(rd), 96'(32'h0010_0000));
    reg_write(32'hC, 32'h1);
    wait_done("t1", 200);
    build_expected(32'h0010_0000, 32'h0010_0100, 4, -1);
    compare_log("t1");
    for (int i = 0; i < 4; i++)
      check_output($sformatf("t1_dst%0d", i), 96'(mem[32'h0010_0100 + 32'(4 * i)]), 96'(src_words[i]));
    reg_read(32'hC, rd);
    check_output("t1_ctrl", 96'(rd), 96'(32'h2));
    check_output("t1_irq_off", 96'(irq_o), 96'(0));

    $display("[TB] test 2: zero-length transfer");
    prepare(32'h0010_0000, 32'h0010_0100, 0);
    reg_write(32'h8, 32'd0);
    reg_write(32'hC, 32'h9);
    check_output("t2_irq_cycle1", 96'(irq_o), 96'(0));
    @(negedge clk_i);
    check_output("t2_irq_cycle2", 96'(irq_o), 96'(1));
    reg_read(32'hC, rd);
    check_output("t2_ctrl", 96'(rd), 96'(32'hA));
    check_output("t2_no_traffic", 96'(log_q.size()), 96'(0));

    $display("[TB] test 3: grant stall on second read");
    stall_max = 0;
    stall_rd_idx = 1;
    stall_rd_len = 5;
    prepare(32'h0010_0000, 32'h0010_0100, 3);
    reg_write(32'h8, 32'd3);
    reg_write(32'hC, 32'h1);
    wait_done("t3", 200);
    build_expected(32'h0010_0000, 32'h0010_0100, 3, -1);
    compare_log("t3");
    check_output("t3_stall_seen", 96'(stable_checks >= 5), 96'(1));
    stall_rd_idx = -1;

    $display("[TB] test 4: bus error on second write");
    stall_max = 1;
    err_wr_idx = 1;
    prepare(32'h0010_0000, 32'h0010_0100, 4);
    reg_write(32'h8, 32'd4);
    reg_write(32'hC, 32'h1);
    wait_done("t4", 200);
    build_expected(32'h0010_0000, 32'h0010_0100, 4, 1);
    compare_log("t4");
    reg_read(32'hC, rd);
    check_output("t4_ctrl", 96'(rd), 96'(32'h6));
    reg_write(32'hC, 32'h6);
    reg_read(32'hC, rd);
    check_output("t4_w1c", 96'(rd), 96'(32'h0));
    err_wr_idx = -1;

    $display("[TB] test 5: writes while busy");
    stall_max = 0;
    stall_wr_fixed = 3;
    prepare(32'h0010_0000, 32'h0010_0100, 4);
    reg_write(32'hC, 32'h1);
    reg_read(32'hC, rd);
    check_output("t5_busy", 96'(rd[0]), 96'(1));
    reg_write(32'h0, 32'h0020_0000);
    reg_write(32'h8, 32'd1);
    reg_write(32'hC, 32'h1);
    reg_read(32'h0, rd);
    check_output("t5_src_kept", 96'(rd), 96'(32'h0010_0000));
    wait_done("t5", 300);
    build_expected(32'h0010_0000, 32'h0010_0100, 4, -1);
    compare_log("t5");
    reg_read(32'h8, rd);
    check_output("t5_len_kept", 96'(rd), 96'(4));

    $display("[TB] test 6: reset during write request");
    stall_wr_fixed = 50;
    prepare(32'h0010_0000, 32'h0010_0100, 4);
    reg_write(32'hC, 32'h9);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk_i);
      if (host_req_o && host_we_o) found = 1;
    end
    check_output("t6_reached_wr_req", 96'(found), 96'(1));
    rst_ni = 1'b0;
    #1;
    check_output("t6_rst_req", 96'(host_req_o), 96'(0));
    check_output("t6_rst_we", 96'(host_we_o), 96'(0));
    check_output("t6_rst_irq", 96'(irq_o), 96'(0));
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    stall_wr_fixed = 0;
    reg_read(32'hC, rd);
    check_output("t6_ctrl_cleared", 96'(rd), 96'(0));
    reg_read(32'h0, rd);
    check_output("t6_src_cleared", 96'(rd), 96'(0));
    prepare(32'h0030_0000, 32'h0030_0800, 2);
    reg_write(32'h0, 32'h0030_0000);
    reg_write(32'h4, 32'h0030_0800);
    reg_write(32'h8, 32'd2);
    reg_write(32'hC, 32'h1);
    wait_done("t6", 200);
    build_expected(32'h0030_0000, 32'h0030_0800, 2, -1);
    compare_log("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
